// File: rtl/seg7_scan_display_n.sv
// Time-multiplexed common-anode seven-segment driver: per-slot blanking, frame
// snapshot of display data, leading-zero suppression and a blinking edit cursor.
module seg7_scan_display_n #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 100,
  parameter int BLINK_DIV    = 25000000,
  parameter int IW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_en,
  input  logic                    edit_en,
  input  logic [IW-1:0]           cursor,
  output logic [NUM_DIGITS-1:0]   seg_en,
  output logic [7:0]              seg_out
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SW-1:0]           slot_cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic                    snap_pend;
  logic                    edit_q;
  logic [IW-1:0]           cursor_q;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_mask;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    sh_lz;

  logic                    slot_end;
  logic                    frame_end;
  logic                    blink_restart;
  logic                    blink_off;
  logic                    lit;
  logic [3:0]              cur_val;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    chain;
  logic [NUM_DIGITS-1:0]   seg_en_d;
  logic [7:0]              seg_out_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign slot_end      = (slot_cnt == SW'(SCAN_DIV - 1));
  assign frame_end     = slot_end && (idx == IW'(NUM_DIGITS - 1));
  assign blink_restart = (edit_en && !edit_q) || (cursor != cursor_q);

  // Slot timing and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_BLANK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (slot_cnt == SW'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Shadow copy refreshed once per frame so a frame never mixes old and new data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_pend <= 1'b1;
      sh_digits <= '0;
      sh_mask   <= '0;
      sh_dp     <= '0;
      sh_lz     <= 1'b0;
    end else begin
      snap_pend <= 1'b0;
      if (snap_pend || frame_end) begin
        sh_digits <= digits;
        sh_mask   <= digit_mask;
        sh_dp     <= dp_mask;
        sh_lz     <= lz_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      edit_q      <= 1'b0;
      cursor_q    <= '0;
    end else begin
      edit_q   <= edit_en;
      cursor_q <= cursor;
      if (blink_restart) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // A digit is suppressed while no enabled non-zero digit sits above it
  always_comb begin
    supp  = '0;
    chain = sh_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      supp[k] = chain && (sh_digits[4*k +: 4] == 4'd0);
      chain   = chain && (!sh_mask[k] || (sh_digits[4*k +: 4] == 4'd0));
    end
  end

  assign cur_val = sh_digits[{idx, 2'b00} +: 4];
  assign lit     = sh_mask[idx] && !supp[idx];
  // A restart this cycle forces the visible phase so the new cursor shows at once
  assign blink_off = edit_en && (cursor == idx) && blink_phase && !blink_restart;

  always_comb begin
    seg_en_d  = '1;
    seg_out_d = 8'hFF;
    if (state_q == ST_SHOW) begin
      if (lit) seg_en_d = ~(NUM_DIGITS'(1) << idx);
      seg_out_d = {~sh_dp[idx], hex_to_seg(cur_val)};
      if (blink_off) seg_out_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_en  <= '1;
      seg_out <= 8'hFF;
    end else begin
      seg_en  <= seg_en_d;
      seg_out <= seg_out_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display_n.sv
// Bench for seg7_scan_display_n: a cycle model pushes the expected {seg_en,seg_out}
// every clock and the scoreboard pops and compares on the falling edge.
module tb_seg7_scan_display_n;

  localparam int N  = 4;
  localparam int SD = 10;
  localparam int BC = 2;
  localparam int BD = 20;
  localparam int IW = 2;

  logic           clk;
  logic           rst;
  logic [4*N-1:0] digits;
  logic [N-1:0]   digit_mask;
  logic [N-1:0]   dp_mask;
  logic           lz_en;
  logic           edit_en;
  logic [IW-1:0]  cursor;
  logic [N-1:0]   seg_en;
  logic [7:0]     seg_out;

  int n_total;
  int n_bad;

  logic [11:0] exp_q[$];

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan_display_n #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .BLINK_DIV   (BD),
    .IW          (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits    (digits),
    .digit_mask(digit_mask),
    .dp_mask   (dp_mask),
    .lz_en     (lz_en),
    .edit_en   (edit_en),
    .cursor    (cursor),
    .seg_en    (seg_en),
    .seg_out   (seg_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: cycle count since reset release, cycles since blink restart
  int          m_c;
  int          m_r;
  logic        m_first;
  logic        m_prev_edit;
  logic [IW-1:0] m_prev_cur;
  logic [4*N-1:0] sh_d;
  logic [N-1:0]   sh_m;
  logic [N-1:0]   sh_dp;
  logic           sh_lz;

  function automatic logic is_supp(input int k);
    if (!sh_lz || k == 0) return 1'b0;
    if (sh_d[4*k +: 4] != 4'd0) return 1'b0;
    for (int j = k + 1; j < N; j++)
      if (sh_m[j] && sh_d[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_c = 0;
      m_r = 0;
      m_first = 1'b1;
      m_prev_edit = 1'b0;
      m_prev_cur = '0;
      sh_d = '0;
      sh_m = '0;
      sh_dp = '0;
      sh_lz = 1'b0;
      exp_q.delete();
    end else begin
      int p;
      int k;
      logic restart;
      logic [3:0] one_hot;
      logic [3:0] e_en;
      logic [7:0] e_out;
      p = m_c % SD;
      k = (m_c / SD) % N;
      restart = (edit_en && !m_prev_edit) || (cursor != m_prev_cur);
      if (p < BC) begin
        e_en = 4'hF;
        e_out = 8'hFF;
      end else begin
        one_hot = 4'b0001 << k;
        e_en = (sh_m[k] && !is_supp(k)) ? ~one_hot : 4'hF;
        e_out = {~sh_dp[k], hex_tab[sh_d[4*k +: 4]][6:0]};
        if (edit_en && cursor == k && ((m_r / BD) % 2 == 1) && !restart) e_out = 8'hFF;
      end
      exp_q.push_back({e_en, e_out});
      if (m_first || (p == SD - 1 && k == N - 1)) begin
        sh_d = digits;
        sh_m = digit_mask;
        sh_dp = dp_mask;
        sh_lz = lz_en;
      end
      m_first = 1'b0;
      m_r = restart ? 0 : m_r + 1;
      m_c++;
      m_prev_edit = edit_en;
      m_prev_cur = cursor;
    end
  end

  // scoreboard
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      chk($sformatf("out@c%0d", m_c), {20'd0, seg_en, seg_out}, {20'd0, e});
    end
  end

  // driver tasks
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_data(input logic [4*N-1:0] d, input logic [N-1:0] m,
                            input logic [N-1:0] dp, input logic lz);
    @(negedge clk);
    digits = d;
    digit_mask = m;
    dp_mask = dp;
    lz_en = lz;
  endtask

  task automatic drive_edit(input logic e, input logic [IW-1:0] c);
    @(negedge clk);
    edit_en = e;
    cursor = c;
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    rst = 1'b1;
    digits = 16'h1234;
    digit_mask = 4'hF;
    dp_mask = 4'h0;
    lz_en = 1'b0;
    edit_en = 1'b0;
    cursor = '0;
    #1;
    chk("rst_en", {28'd0, seg_en}, 32'hF);
    chk("rst_out", {24'd0, seg_out}, 32'hFF);
    run(3);
    rst = 1'b0;

    // plain scan, one full frame plus wrap
    run(45);
    // leading-zero suppression on, then off
    drive_data(16'h0050, 4'hF, 4'h0, 1'b1);
    run(80);
    drive_data(16'h0050, 4'hF, 4'h0, 1'b0);
    run(45);
    // decimal point on digit 2
    drive_data(16'h0800, 4'hF, 4'b0100, 1'b0);
    run(45);
    // suppression chain skips a disabled non-zero digit
    drive_data(16'h0705, 4'b1011, 4'h0, 1'b1);
    run(45);
    // blink on cursor 1, then move cursor mid-off-phase
    drive_data(16'h1234, 4'hF, 4'h0, 1'b0);
    drive_edit(1'b1, 2'd1);
    run(70);
    drive_edit(1'b1, 2'd2);
    run(60);
    drive_edit(1'b0, 2'd2);
    // mid-frame data changes at random points
    for (int i = 0; i < 8; i++) begin
      drive_data(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      if (i % 3 == 0) drive_edit(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      run($urandom_range(3, 30));
    end

    // asynchronous reset in the middle of a lit slot
    drive_data(16'h1234, 4'hF, 4'h0, 1'b0);
    drive_edit(1'b0, 2'd0);
    begin
      int guard;
      guard = 0;
      while (m_c % SD != 6 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk("show_wait", {31'd0, guard < 100}, 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", {28'd0, seg_en}, 32'hF);
    chk("mid_rst_out", {24'd0, seg_out}, 32'hFF);
    run(2);
    rst = 1'b0;
    run(50);

    chk("enough_checks", {31'd0, n_total > 400}, 32'd1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
